// File: rtl/bit_serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-index width calculation.
package bit_serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index must be at least one bit wide even when a single-bit operand is used.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : bit_serial_add_pkg

// File: rtl/full_add.sv
// Single-bit full adder cell shared by every bit position of the serial adder.
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (a_i & carry_i) | (b_i & carry_i);

endmodule : full_add

// File: rtl/bit_serial_add.sv
// Bit-serial adder: one full-adder cell processes the operands LSB first, one
// bit per cycle, with valid/ready handshakes on both the operand and result side.
module bit_serial_add
  import bit_serial_add_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               carry_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] sum_o,
  output logic               carry_o
);

  localparam int IdxW = idx_width(width_p);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(width_p - 1);

  state_t              state_q, state_d;
  logic [IdxW-1:0]     idx_q,   idx_d;
  logic [width_p-1:0]  a_q,     a_d;
  logic [width_p-1:0]  b_q,     b_d;
  logic [width_p-1:0]  sum_q,   sum_d;
  logic                carry_q, carry_d;

  logic fa_sum;
  logic fa_carry;

  full_add u_full_add (
    .a_i     (a_q[idx_q]),
    .b_i     (b_q[idx_q]),
    .carry_i (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ready_o = 1'b0;
    valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = carry_i;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[idx_q] = fa_sum;
        carry_d      = fa_carry;
        // The index parks at 0 after the last bit so it never runs past width_p-1.
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and
  // clears every register, including the datapath, so outputs are deterministic.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule : bit_serial_add
